// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester-side handshake and the byte-engine handshake that the
// round-robin UART TX arbiter sits between.
//   req        requester i asks for service (level, held until its ack)
//   req_data   requester i word at [32i+31:32i]
//   req_len    requester i byte count minus 1 at [2i+1:2i]
//   grant      one-hot, owner of the byte engine (LOAD of first byte .. DONE)
//   ack        one-cycle pulse for the served requester
//   busy       arbiter is not idle
//   ld_tx_data / tx_enable / tx_data   byte-engine load/enable/data
//   tx_empty   byte engine can accept a new byte
// Modports: slave = the arbiter, master = requesters plus byte engine.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   req_data;
  logic [2*NREQ-1:0]    req_len;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      ack;
  logic                 busy;
  logic                 ld_tx_data;
  logic                 tx_enable;
  logic [7:0]           tx_data;
  logic                 tx_empty;

  modport slave (
    input  req, req_data, req_len, tx_empty,
    output grant, ack, busy, ld_tx_data, tx_enable, tx_data
  );

  modport master (
    output req, req_data, req_len, tx_empty,
    input  grant, ack, busy, ld_tx_data, tx_enable, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one uart_tx byte serializer between NREQ
// requesters, each sending a 1..4 byte frame (MSB-first within the low len+1
// bytes of a 32-bit word). Runs entirely in the txclk (baud) domain.
// Ports:
//   txclk  baud-rate clock, all logic on posedge
//   reset  asynchronous, active-high (also resets the byte engine)
//   bus    uart_tx_arbiter_if.slave: requester handshake + engine handshake
// All outputs are registered; they are computed from the next state.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int GAP  = 2
) (
  input  logic              txclk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_DONE = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [31:0]     r_sh, w_sh_nxt;
  logic [1:0]      r_len, w_len_nxt;
  logic [1:0]      r_idx, w_idx_nxt;
  logic [3:0]      r_gap, w_gap_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic [NREQ-1:0] r_ack, w_ack_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_ld, w_ld_nxt;
  logic            r_en, w_en_nxt;
  logic [7:0]      r_data, w_data_nxt;

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_cand;
  logic [31:0]     w_word;
  logic [1:0]      w_wlen;

  // Round-robin winner search: first requester after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_cand  = r_ptr;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end else begin
        w_found = w_found;
      end
    end
    w_word = bus.req_data[32*int'(w_win) +: 32];
    w_wlen = bus.req_len[2*int'(w_win) +: 2];
  end

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sh_nxt    = r_sh;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_gap_nxt   = r_gap;
    w_grant_nxt = r_grant;
    w_ack_nxt   = '0;
    w_ld_nxt    = 1'b0;
    w_en_nxt    = 1'b0;
    w_data_nxt  = r_data;
    case (r_state)
      S_IDLE: begin
        if (w_found && bus.tx_empty) begin
          w_state_nxt = S_LOAD;
          w_ptr_nxt   = w_win;
          w_grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
          w_len_nxt   = w_wlen;
          // Left-align the frame so the first byte to send sits in [31:24].
          w_sh_nxt    = w_word << {(2'd3 - w_wlen), 3'b000};
          w_idx_nxt   = 2'd0;
          w_ld_nxt    = 1'b1;
          w_data_nxt  = w_sh_nxt[31:24];
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_SEND;
        w_en_nxt    = 1'b1;
      end
      S_SEND: begin
        if (bus.tx_empty) begin
          if (r_idx == r_len) begin
            w_state_nxt = S_DONE;
            w_ack_nxt   = r_grant;
          end else begin
            w_state_nxt = S_LOAD;
            w_sh_nxt    = {r_sh[23:0], 8'h00};
            w_idx_nxt   = r_idx + 2'd1;
            w_ld_nxt    = 1'b1;
            w_data_nxt  = w_sh_nxt[31:24];
          end
        end else begin
          w_state_nxt = S_SEND;
          w_en_nxt    = 1'b1;
        end
      end
      S_DONE: begin
        w_grant_nxt = '0;
        if (GAP == 0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = 4'(GAP - 1);
        end
      end
      S_GAP: begin
        if (r_gap == 4'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt   = r_gap - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State, datapath and output registers; reset discards any partial frame.
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= PW'(NREQ - 1);
      r_sh    <= 32'h0000_0000;
      r_len   <= 2'd0;
      r_idx   <= 2'd0;
      r_gap   <= 4'd0;
      r_grant <= '0;
      r_ack   <= '0;
      r_busy  <= 1'b0;
      r_ld    <= 1'b0;
      r_en    <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sh    <= w_sh_nxt;
      r_len   <= w_len_nxt;
      r_idx   <= w_idx_nxt;
      r_gap   <= w_gap_nxt;
      r_grant <= w_grant_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
      r_ld    <= w_ld_nxt;
      r_en    <= w_en_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign bus.grant      = r_grant;
  assign bus.ack        = r_ack;
  assign bus.busy       = r_busy;
  assign bus.ld_tx_data = r_ld;
  assign bus.tx_enable  = r_en;
  assign bus.tx_data    = r_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Bench for uart_tx_arbiter with a behavioural byte-engine model and an
// event-level round-robin reference model (frame order, ack cycles, bytes).
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int GAP  = 2;
  localparam int MAXF = 8;

  logic txclk = 1'b0;
  logic reset;
  logic hold_empty;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus();

  uart_tx_arbiter #(.NREQ(NREQ), .GAP(GAP)) dut (
    .txclk (txclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 txclk = ~txclk;

  // cycle number of the cycle that starts at each posedge
  always @(posedge txclk) cyc <= cyc + 1;

  typedef struct { int cyc; int who; logic [7:0] b; } ev_t;
  ev_t load_log[$];
  ev_t ack_log[$];
  ev_t exp_ack[$];
  ev_t exp_byte[$];

  function automatic int onehot_idx(logic [NREQ-1:0] v);
    int r = -1;
    int c = 0;
    for (int i = 0; i < NREQ; i++) if (v[i]) begin r = i; c++; end
    return (c == 1) ? r : -1;
  endfunction

  // byte engine: load on ld&empty, 10 enabled cycles, empty after the 10th
  logic       eng_empty;
  logic       tx_out;
  logic [7:0] eng_sh;
  int         eng_cnt;
  assign bus.tx_empty = eng_empty & ~hold_empty;

  always @(posedge txclk or posedge reset) begin
    if (reset) begin
      eng_empty <= 1'b1;
      tx_out    <= 1'b1;
      eng_cnt   <= 0;
    end else if (bus.ld_tx_data && bus.tx_empty) begin
      eng_sh    <= bus.tx_data;
      eng_empty <= 1'b0;
      eng_cnt   <= 0;
      load_log.push_back('{cyc, onehot_idx(bus.grant), bus.tx_data});
    end else if (bus.tx_enable && !eng_empty) begin
      case (eng_cnt)
        0:       tx_out <= 1'b0;
        9:       begin tx_out <= 1'b1; eng_empty <= 1'b1; end
        default: tx_out <= eng_sh[eng_cnt-1];
      endcase
      eng_cnt <= eng_cnt + 1;
    end
  end

  always @(negedge txclk) begin
    if (!reset && bus.ack != '0) ack_log.push_back('{cyc, onehot_idx(bus.ack), 8'h00});
  end

  // frame store per requester
  logic [31:0] fw [NREQ][MAXF];
  logic [1:0]  fl [NREQ][MAXF];
  int          fh [NREQ];
  int          fn [NREQ];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic at_cyc(int k);
    int n;
    n = k - cyc;
    repeat (n) @(posedge txclk);
    @(negedge txclk);
  endtask

  task automatic add_frame(int i, logic [31:0] w, logic [1:0] l);
    fw[i][fn[i]] = w;
    fl[i][fn[i]] = l;
    fn[i]++;
  endtask

  task automatic present(int i);
    if (fh[i] < fn[i]) begin
      bus.req[i]             = 1'b1;
      bus.req_data[32*i+:32] = fw[i][fh[i]];
      bus.req_len[2*i+:2]    = fl[i][fh[i]];
    end else begin
      bus.req[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.req    = '0;
    hold_empty = 1'b0;
    repeat (2) @(posedge txclk);
    #2 reset = 1'b0;
    ack_log.delete(); load_log.delete(); exp_ack.delete(); exp_byte.delete();
    for (int i = 0; i < NREQ; i++) begin fh[i] = 0; fn[i] = 0; end
  endtask

  // Reference: pure round-robin among requesters with frames left; frame of n
  // bytes decided at t acks at t+12n+1 and frees the arbiter at t+12n+2+GAP.
  task automatic build_model(int t0);
    int ptr = NREQ - 1;
    int h[NREQ];
    int t = t0;
    int j;
    int n;
    for (int i = 0; i < NREQ; i++) h[i] = fh[i];
    forever begin
      j = -1;
      for (int k = 1; k <= NREQ && j < 0; k++)
        if (h[(ptr + k) % NREQ] < fn[(ptr + k) % NREQ]) j = (ptr + k) % NREQ;
      if (j < 0) break;
      n = int'(fl[j][h[j]]) + 1;
      for (int b = n - 1; b >= 0; b--)
        exp_byte.push_back('{0, j, 8'(fw[j][h[j]] >> (8 * b))});
      exp_ack.push_back('{t + 12 * n + 1, j, 8'h00});
      t = t + 12 * n + 2 + GAP;
      ptr = j;
      h[j]++;
    end
  endtask

  // Requesters advance to their next frame on ack; optionally scramble the
  // granted requester's inputs mid-frame (must be ignored by the arbiter).
  task automatic serve(int budget, bit scramble);
    bit done;
    done = 1'b0;
    for (int t = 0; t < budget && !done; t++) begin
      @(posedge txclk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ack[i]) begin
          fh[i]++;
          present(i);
        end else if (scramble && bus.grant[i]) begin
          bus.req_data[32*i+:32] = $urandom;
          bus.req_len[2*i+:2]    = 2'($urandom);
          bus.req[i]             = 1'($urandom);
        end
      end
      done = !bus.busy;
      for (int i = 0; i < NREQ; i++) if (fh[i] < fn[i]) done = 1'b0;
    end
    chk("drain", done, 1);
  endtask

  task automatic compare_logs(string tag);
    chk({tag, "_nack"}, ack_log.size(), exp_ack.size());
    chk({tag, "_nbyte"}, load_log.size(), exp_byte.size());
    for (int i = 0; i < ack_log.size() && i < exp_ack.size(); i++) begin
      chk($sformatf("%s_ackcyc%0d", tag, i), ack_log[i].cyc, exp_ack[i].cyc);
      chk($sformatf("%s_ackwho%0d", tag, i), ack_log[i].who, exp_ack[i].who);
    end
    for (int i = 0; i < load_log.size() && i < exp_byte.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), load_log[i].b, exp_byte[i].b);
      chk($sformatf("%s_bwho%0d", tag, i), load_log[i].who, exp_byte[i].who);
    end
  endtask

  initial begin : main
    int k;
    int k3;
    logic [7:0] t1b [4];
    t1b = '{8'hA5, 8'hC3, 8'h0F, 8'h81};

    // reset values
    reset = 1'b0; hold_empty = 1'b0;
    bus.req = '0; bus.req_data = '0; bus.req_len = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_grant", bus.grant, 0); chk("rst_ack", bus.ack, 0);
    chk("rst_busy", bus.busy, 0);   chk("rst_ld", bus.ld_tx_data, 0);
    chk("rst_en", bus.tx_enable, 0); chk("rst_data", bus.tx_data, 0);
    do_reset();

    // T1: req0, len 3, 0xA5C30F81
    @(posedge txclk); #1; k = cyc;
    bus.req[0] = 1'b1; bus.req_data[31:0] = 32'hA5C30F81; bus.req_len[1:0] = 2'd3;
    at_cyc(k + 1);
    chk("t1_grant", bus.grant, 4'b0001); chk("t1_ld", bus.ld_tx_data, 1);
    chk("t1_busy", bus.busy, 1);
    at_cyc(k + 48); chk("t1_noack48", bus.ack, 0);
    at_cyc(k + 49); chk("t1_ack", bus.ack, 4'b0001);
    @(posedge txclk); #1; bus.req[0] = 1'b0;
    at_cyc(k + 50); chk("t1_ack_clr", bus.ack, 0); chk("t1_grant_clr", bus.grant, 0);
    at_cyc(k + 51); chk("t1_busy51", bus.busy, 1);
    at_cyc(k + 52); chk("t1_busy52", bus.busy, 0);
    chk("t1_nbyte", load_log.size(), 4);
    for (int i = 0; i < 4 && i < load_log.size(); i++) begin
      chk($sformatf("t1_byte%0d", i), load_log[i].b, t1b[i]);
      chk($sformatf("t1_ldcyc%0d", i), load_log[i].cyc, k + 1 + 12 * i);
    end
    chk("t1_nack", ack_log.size(), 1);

    // T2: req1, len 0 -> one byte 0x81, ack at c13
    ack_log.delete(); load_log.delete();
    @(posedge txclk); #1; k = cyc;
    bus.req[1] = 1'b1; bus.req_data[63:32] = 32'h12345681; bus.req_len[3:2] = 2'd0;
    at_cyc(k + 13); chk("t2_ack", bus.ack, 4'b0010);
    @(posedge txclk); #1; bus.req[1] = 1'b0;
    at_cyc(k + 30);
    chk("t2_nbyte", load_log.size(), 1);
    if (load_log.size() > 0) chk("t2_byte", load_log[0].b, 8'h81);
    chk("t2_nack", ack_log.size(), 1);
    if (ack_log.size() > 0) chk("t2_ackcyc", ack_log[0].cyc, k + 13);

    // T3: all four at once after reset -> 0,1,2,3
    do_reset();
    for (int i = 0; i < NREQ; i++) add_frame(i, $urandom, 2'($urandom_range(0, 3)));
    @(posedge txclk); #1; k = cyc;
    for (int i = 0; i < NREQ; i++) present(i);
    build_model(k);
    serve(1000, 1'b0);
    compare_logs("t3");
    for (int i = 0; i < NREQ && i < ack_log.size(); i++)
      chk($sformatf("t3_order%0d", i), ack_log[i].who, i);

    // T4: req0 re-requests immediately; req2/req3 pending -> 0,2,3,0
    do_reset();
    add_frame(0, $urandom, 2'd0); add_frame(0, $urandom, 2'd1);
    @(posedge txclk); #1; k = cyc;
    present(0);
    at_cyc(k + 3);
    add_frame(2, $urandom, 2'd1); add_frame(3, $urandom, 2'd2);
    present(2); present(3);
    serve(1000, 1'b0);
    chk("t4_nack", ack_log.size(), 4);
    if (ack_log.size() == 4) begin
      chk("t4_o0", ack_log[0].who, 0); chk("t4_o1", ack_log[1].who, 2);
      chk("t4_o2", ack_log[2].who, 3); chk("t4_o3", ack_log[3].who, 0);
    end

    // T5: tx_empty held low in IDLE blocks the grant
    do_reset();
    hold_empty = 1'b1;
    @(posedge txclk); #1; k = cyc;
    bus.req[0] = 1'b1; bus.req_data[31:0] = 32'h00000077; bus.req_len[1:0] = 2'd0;
    at_cyc(k + 4);
    chk("t5_grant_held", bus.grant, 0); chk("t5_busy_held", bus.busy, 0);
    @(posedge txclk); #1; hold_empty = 1'b0;
    at_cyc(k + 6);
    chk("t5_grant", bus.grant, 4'b0001); chk("t5_busy", bus.busy, 1);
    chk("t5_data", bus.tx_data, 8'h77);
    @(posedge txclk); #1; bus.req[0] = 1'b0;
    at_cyc(k + 25);

    // T6: reset during SEND of byte 2 discards the frame
    do_reset();
    @(posedge txclk); #1; k = cyc;
    bus.req[1] = 1'b1; bus.req_data[63:32] = 32'hDEADBEEF; bus.req_len[3:2] = 2'd3;
    at_cyc(k + 2);
    bus.req[3] = 1'b1; bus.req_data[127:96] = 32'h0000005A; bus.req_len[7:6] = 2'd0;
    at_cyc(k + 18);
    chk("t6_send", bus.tx_enable, 1); chk("t6_grant1", bus.grant, 4'b0010);
    #1 reset = 1'b1; bus.req[1] = 1'b0;
    #1;
    chk("t6_grant", bus.grant, 0); chk("t6_ack", bus.ack, 0);
    chk("t6_busy", bus.busy, 0);   chk("t6_ld", bus.ld_tx_data, 0);
    chk("t6_en", bus.tx_enable, 0); chk("t6_data", bus.tx_data, 0);
    chk("t6_txout", tx_out, 1);
    @(posedge txclk); #2 reset = 1'b0; k3 = cyc;
    at_cyc(k3 + 1); chk("t6_grant3", bus.grant, 4'b1000); chk("t6_data3", bus.tx_data, 8'h5A);
    at_cyc(k3 + 13); chk("t6_ack3", bus.ack, 4'b1000);
    @(posedge txclk); #1; bus.req[3] = 1'b0;
    at_cyc(k3 + 20);
    chk("t6_nack", ack_log.size(), 1);
    if (ack_log.size() > 0) chk("t6_ackwho", ack_log[0].who, 3);

    // Random: several frames per requester, inputs scrambled mid-frame
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
        int nf;
        nf = $urandom_range(1, 3);
        for (int f = 0; f < nf; f++) add_frame(i, $urandom, 2'($urandom_range(0, 3)));
      end
      @(posedge txclk); #1; k = cyc;
      for (int i = 0; i < NREQ; i++) present(i);
      build_model(k);
      serve(4000, 1'b1);
      compare_logs($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
